dmem_resp: RTL and testbench
============================

Name: dmem_resp

Overview:
Data-side memory responder. It sits between the MEM stage's data request outputs (TRANDATADDR, SORL, WRITEMEM, DADDR, DATAO) and an external word-wide memory bus with a req/ack handshake. It returns read data on MEMDATAI and stalls the pipeline with MEMSTALL until each access completes. It also flags misaligned accesses, bus errors and bus timeouts back to the pipeline.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (word only; no byte lanes)
TIMEOUT, 255, max cycles waited for BUS_ACK before forcing a bus error (1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
TRANDATADDR  in  1  data access request valid (load or store)
SORL  in  1  1 = store, 0 = load
WRITEMEM  in  1  store enable; a store is issued only if SORL and WRITEMEM are both 1
DADDR  in  ADDR_W  access address
DATAO  in  DATA_W  store data
MEMDATAI  out  DATA_W  load data to MEM stage (registered)
MEMSTALL  out  1  hold the pipeline this cycle
ADDRERR  out  1  misaligned access (combinational, IDLE only)
BUSERR  out  1  access ended with BUS_ERR or timeout (valid in DONE)
BUS_REQ  out  1  bus request
BUS_WE  out  1  bus write
BUS_ADDR  out  ADDR_W  bus address, word aligned
BUS_WDATA  out  DATA_W  bus write data
BUS_RDATA  in  DATA_W  bus read data, valid with BUS_ACK
BUS_ACK  in  1  bus access complete
BUS_ERR  in  1  bus error, qualified by BUS_ACK

Behaviour:
- Reset (async, reset=1):
  - state=IDLE; MEMDATAI=0; BUSERR=0.
  - BUS_REQ=0, BUS_WE=0, BUS_ADDR=0, BUS_WDATA=0; counter=0.
  - MEMSTALL=0; ADDRERR=0.
- Reset asserted mid-access: abandon the access, return to IDLE, drop BUS_REQ immediately. No completion is reported.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Request with DADDR[1:0]!=0 (misaligned): ADDRERR=1, MEMSTALL=0, no bus activity, stay in IDLE.
  - Request with aligned DADDR: MEMSTALL=1 (combinational).
    - Capture DADDR, DATAO, and (SORL&WRITEMEM) into the BUS_* registers.
    - Clear counter; next state REQ.
  - No request: MEMSTALL=0.
- REQ:
  - BUS_REQ=1; BUS_ADDR, BUS_WE, BUS_WDATA held stable; MEMSTALL=1.
  - BUS_ACK=1 sampled: MEMDATAI<=BUS_RDATA on loads (unchanged on stores); BUSERR<=BUS_ERR; next state DONE.
  - Otherwise counter increments. When counter reaches TIMEOUT-1 without ack: BUSERR<=1, MEMDATAI<=0 on loads; next state DONE.
- DONE:
  - BUS_REQ=0; MEMSTALL=0; the pipeline advances at this edge; next state IDLE.
  - BUSERR is cleared on leaving DONE.
- Latency:
  - Load/store with ack in first REQ cycle: MEMSTALL high 2 cycles; data visible in the 3rd cycle (DONE).
  - Each extra wait cycle adds 1.
- Back-to-back accesses: a request present in the cycle after DONE is accepted from IDLE. There is no bubble beyond the DONE cycle.
- BUS_ACK/BUS_ERR outside REQ are ignored.
- BUS_ERR without BUS_ACK is ignored.
- MEMDATAI holds its last value between accesses.

Decomposition:
- Shared package dmem_pkg holds:
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2).
  - The default TIMEOUT constant.
  - The word-alignment mask constant.
- One sub-module, dmem_timeout_cnt: 8-bit counter with clear/enable, async reset and an expire flag at TIMEOUT-1.

Test Plan:
- Aligned load, DADDR=0x0000_1000, BUS_ACK in first REQ cycle with BUS_RDATA=0xDEAD_BEEF:
  - BUS_REQ=1 for 1 cycle with BUS_WE=0, BUS_ADDR=0x1000.
  - MEMSTALL high 2 cycles; MEMDATAI=0xDEAD_BEEF in DONE; BUSERR=0.
- Store, SORL=WRITEMEM=1, DADDR=0x2004, DATAO=0x1234_5678, ack after 3 wait cycles:
  - BUS_WE=1 and BUS_WDATA=0x1234_5678 stable for 4 REQ cycles.
  - MEMSTALL high 5 cycles; MEMDATAI unchanged.
- Misaligned load, DADDR=0x0000_1002:
  - ADDRERR=1 the same cycle; MEMSTALL=0; BUS_REQ stays 0; state stays IDLE.
- No ack, TIMEOUT=4:
  - After 4 REQ cycles the block enters DONE with BUSERR=1 and MEMDATAI=0.
  - BUS_REQ drops; MEMSTALL=0 in DONE.
- Ack with BUS_ERR=1 on a load: DONE with BUSERR=1; MEMDATAI=BUS_RDATA.
- Reset asserted in the 2nd REQ cycle:
  - BUS_REQ=0, MEMSTALL=0, MEMDATAI=0 immediately.
  - After release, a fresh load completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory responder: FSM encoding,
// default bus timeout and the word-alignment check.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_t;

  // Longest wait for BUS_ACK before the access is forced to a bus error.
  localparam int DEFAULT_TIMEOUT = 255;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// 8-bit wait counter for the bus handshake. It is cleared when an access
// starts, advances while waiting, and flags expiry at TIMEOUT-1 so that the
// number of REQ cycles before a forced error equals TIMEOUT.
module dmem_timeout_cnt
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count_reg;

  // Count waited cycles; saturate at the expiry value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= 8'd0;
    end else if (clear) begin
      count_reg <= 8'd0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign expire = (count_reg == LAST);

endmodule

// File: rtl/dmem_resp.sv
// Data-side memory responder: turns MEM-stage load/store requests into a
// req/ack word bus transaction, stalls the pipeline until the access ends,
// and reports misalignment, bus errors and bus timeouts.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              TRANDATADDR,
  input  logic              SORL,
  input  logic              WRITEMEM,
  input  logic [ADDR_W-1:0] DADDR,
  input  logic [DATA_W-1:0] DATAO,
  output logic [DATA_W-1:0] MEMDATAI,
  output logic              MEMSTALL,
  output logic              ADDRERR,
  output logic              BUSERR,
  output logic              BUS_REQ,
  output logic              BUS_WE,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic [DATA_W-1:0] BUS_WDATA,
  input  logic [DATA_W-1:0] BUS_RDATA,
  input  logic              BUS_ACK,
  input  logic              BUS_ERR
);

  dmem_state_t       state_reg;
  logic [DATA_W-1:0] mem_data_reg;
  logic              bus_err_reg;
  logic              bus_req_reg;
  logic              bus_we_reg;
  logic [ADDR_W-1:0] bus_addr_reg;
  logic [DATA_W-1:0] bus_wdata_reg;

  logic aligned;
  logic accept;
  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expire;

  assign aligned    = is_word_aligned(DADDR[1:0]);
  assign accept     = (state_reg == ST_IDLE) && TRANDATADDR && aligned;
  assign cnt_clear  = (state_reg == ST_IDLE);
  assign cnt_enable = (state_reg == ST_REQ) && !BUS_ACK;

  dmem_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .enable(cnt_enable),
    .expire(cnt_expire)
  );

  // Access sequencer: capture in IDLE, wait for ack or timeout in REQ,
  // report for one cycle in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      mem_data_reg  <= '0;
      bus_err_reg   <= 1'b0;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            bus_addr_reg  <= {DADDR[ADDR_W-1:2], 2'b00};
            bus_wdata_reg <= DATAO;
            bus_we_reg    <= SORL & WRITEMEM;
            bus_req_reg   <= 1'b1;
            state_reg     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (BUS_ACK) begin
            if (!bus_we_reg) begin
              mem_data_reg <= BUS_RDATA;
            end
            bus_err_reg <= BUS_ERR;
            bus_req_reg <= 1'b0;
            state_reg   <= ST_DONE;
          end else if (cnt_expire) begin
            if (!bus_we_reg) begin
              mem_data_reg <= '0;
            end
            bus_err_reg <= 1'b1;
            bus_req_reg <= 1'b0;
            state_reg   <= ST_DONE;
          end
        end
        ST_DONE: begin
          bus_err_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
        default: begin
          bus_req_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall and misalignment flags react within the request cycle; both are
  // forced low while reset is held so an abandoned access releases the pipe.
  always_comb begin
    MEMSTALL = 1'b0;
    ADDRERR  = 1'b0;
    if (!reset) begin
      MEMSTALL = accept || (state_reg == ST_REQ);
      ADDRERR  = (state_reg == ST_IDLE) && TRANDATADDR && !aligned;
    end
  end

  assign MEMDATAI  = mem_data_reg;
  assign BUSERR    = bus_err_reg;
  assign BUS_REQ   = bus_req_reg;
  assign BUS_WE    = bus_we_reg;
  assign BUS_ADDR  = bus_addr_reg;
  assign BUS_WDATA = bus_wdata_reg;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp with a short bus timeout.
module tb_dmem_resp;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        TRANDATADDR = 1'b0;
  logic        SORL = 1'b0;
  logic        WRITEMEM = 1'b0;
  logic [31:0] DADDR = '0;
  logic [31:0] DATAO = '0;
  logic [31:0] MEMDATAI;
  logic        MEMSTALL;
  logic        ADDRERR;
  logic        BUSERR;
  logic        BUS_REQ;
  logic        BUS_WE;
  logic [31:0] BUS_ADDR;
  logic [31:0] BUS_WDATA;
  logic [31:0] BUS_RDATA = '0;
  logic        BUS_ACK = 1'b0;
  logic        BUS_ERR = 1'b0;

  dmem_resp #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .TRANDATADDR(TRANDATADDR), .SORL(SORL), .WRITEMEM(WRITEMEM),
    .DADDR(DADDR), .DATAO(DATAO),
    .MEMDATAI(MEMDATAI), .MEMSTALL(MEMSTALL), .ADDRERR(ADDRERR), .BUSERR(BUSERR),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA),
    .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK), .BUS_ERR(BUS_ERR)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_cnt = 0;

  // Expected outputs for the current cycle, set by the stimulus code.
  logic        chk_en = 1'b0;
  logic        bus_chk = 1'b0;
  logic        exp_stall, exp_req, exp_addrerr, exp_buserr, exp_we;
  logic [31:0] exp_memdata, exp_addr, exp_wdata;
  logic [31:0] model_mem = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (MEMSTALL === 1'b1) stall_cnt++;
    if (chk_en) begin
      check("MEMSTALL", {31'd0, MEMSTALL}, {31'd0, exp_stall});
      check("BUS_REQ",  {31'd0, BUS_REQ},  {31'd0, exp_req});
      check("ADDRERR",  {31'd0, ADDRERR},  {31'd0, exp_addrerr});
      check("BUSERR",   {31'd0, BUSERR},   {31'd0, exp_buserr});
      check("MEMDATAI", MEMDATAI, exp_memdata);
      if (bus_chk) begin
        check("BUS_WE",    {31'd0, BUS_WE}, {31'd0, exp_we});
        check("BUS_ADDR",  BUS_ADDR, exp_addr);
        check("BUS_WDATA", BUS_WDATA, exp_wdata);
      end
    end
  end

  // One cycle with no accepted access (idle, or misaligned request).
  task automatic idle_cycle(input logic trans, input logic [31:0] addr, input logic stray_ack);
    @(posedge clk); #1;
    TRANDATADDR = trans; DADDR = addr; SORL = 1'b0; WRITEMEM = 1'b0;
    BUS_ACK = stray_ack; BUS_ERR = stray_ack; BUS_RDATA = 32'h0BAD_0BAD;
    exp_stall = 1'b0; exp_req = 1'b0; exp_buserr = 1'b0;
    exp_addrerr = trans && (addr[1:0] != 2'b00);
    exp_memdata = model_mem; bus_chk = 1'b0;
    $display("[TB] idle trans=%0b addr=%h stray_ack=%0b", trans, addr, stray_ack);
  endtask

  // Full aligned access: ack arrives in REQ cycle ack_wait (>= TO means never).
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic sorl, input logic wrmem, input int ack_wait,
                           input logic [31:0] rdata, input logic err);
    logic store;
    logic timed_out;
    int   req_cycles;
    store      = sorl & wrmem;
    timed_out  = (ack_wait >= TO);
    req_cycles = timed_out ? TO : ack_wait + 1;
    // request cycle in IDLE
    @(posedge clk); #1;
    TRANDATADDR = 1'b1; SORL = sorl; WRITEMEM = wrmem; DADDR = addr; DATAO = wdata;
    BUS_ACK = 1'b0; BUS_ERR = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0; exp_addrerr = 1'b0; exp_buserr = 1'b0;
    exp_memdata = model_mem; bus_chk = 1'b0;
    // wait cycles on the bus; BUS_ERR without ack must be ignored
    for (int j = 0; j < req_cycles; j++) begin
      @(posedge clk); #1;
      BUS_ACK   = (j == ack_wait);
      BUS_ERR   = (j == ack_wait) ? err : 1'b1;
      BUS_RDATA = (j == ack_wait) ? rdata : ~rdata;
      exp_stall = 1'b1; exp_req = 1'b1; bus_chk = 1'b1;
      exp_we = store; exp_addr = addr & 32'hFFFF_FFFC; exp_wdata = wdata;
    end
    if (!store) model_mem = timed_out ? 32'h0 : rdata;
    // DONE cycle; an ack here lies outside REQ and must be ignored
    @(posedge clk); #1;
    TRANDATADDR = 1'b0;
    BUS_ACK = 1'b1; BUS_ERR = 1'b1; BUS_RDATA = 32'h0BAD_0BAD;
    exp_stall = 1'b0; exp_req = 1'b0; bus_chk = 1'b0;
    exp_memdata = model_mem; exp_buserr = timed_out | err;
    $display("[TB] access addr=%h store=%0b ack_wait=%0d rdata=%h err=%0b -> mem=%h buserr=%0b",
             addr, store, ack_wait, rdata, err, model_mem, timed_out | err);
  endtask

  int base;

  initial begin
    exp_stall = 1'b0; exp_req = 1'b0; exp_addrerr = 1'b0; exp_buserr = 1'b0;
    exp_we = 1'b0; exp_memdata = '0; exp_addr = '0; exp_wdata = '0;
    #3;
    check("rst MEMDATAI", MEMDATAI, 32'h0);
    check("rst BUS_REQ",  {31'd0, BUS_REQ}, 32'h0);
    check("rst MEMSTALL", {31'd0, MEMSTALL}, 32'h0);
    check("rst ADDRERR",  {31'd0, ADDRERR}, 32'h0);
    check("rst BUSERR",   {31'd0, BUSERR}, 32'h0);
    check("rst BUS_WE",   {31'd0, BUS_WE}, 32'h0);
    check("rst BUS_ADDR", BUS_ADDR, 32'h0);
    check("rst BUS_WDATA", BUS_WDATA, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    idle_cycle(1'b0, 32'h0, 1'b0);

    // aligned load, ack in first REQ cycle
    base = stall_cnt;
    do_access(32'h0000_1000, 32'h0, 1'b0, 1'b0, 0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk); #1;
    check("load1 stall cycles", stall_cnt - base, 2);
    check("load1 data", MEMDATAI, 32'hDEAD_BEEF);
    check("load1 buserr", {31'd0, BUSERR}, 32'h0);

    // back-to-back store, ack after 3 wait cycles (same cycle as expiry)
    base = stall_cnt;
    do_access(32'h0000_2004, 32'h1234_5678, 1'b1, 1'b1, 3, 32'h5555_AAAA, 1'b0);
    @(negedge clk); #1;
    check("store stall cycles", stall_cnt - base, 5);
    check("store keeps data", MEMDATAI, 32'hDEAD_BEEF);
    check("store buserr", {31'd0, BUSERR}, 32'h0);

    // misaligned load and store, plus stray ack while idle
    idle_cycle(1'b1, 32'h0000_1002, 1'b0);
    #2;
    check("misaligned ADDRERR", {31'd0, ADDRERR}, 32'h1);
    check("misaligned MEMSTALL", {31'd0, MEMSTALL}, 32'h0);
    idle_cycle(1'b0, 32'h0000_1002, 1'b1);
    idle_cycle(1'b1, 32'h0000_2007, 1'b0);
    idle_cycle(1'b0, 32'h0, 1'b0);

    // load with no ack: timeout after TO REQ cycles
    base = stall_cnt;
    do_access(32'h0000_3000, 32'h0, 1'b0, 1'b0, 255, 32'h1111_1111, 1'b0);
    @(negedge clk); #1;
    check("timeout stall cycles", stall_cnt - base, 5);
    check("timeout buserr", {31'd0, BUSERR}, 32'h1);
    check("timeout data", MEMDATAI, 32'h0);

    // load acked with BUS_ERR
    do_access(32'h0000_4008, 32'h0, 1'b0, 1'b0, 1, 32'hA5A5_5A5A, 1'b1);
    @(negedge clk); #1;
    check("err buserr", {31'd0, BUSERR}, 32'h1);
    check("err data", MEMDATAI, 32'hA5A5_5A5A);

    // SORL without WRITEMEM is a load
    do_access(32'h0000_5000, 32'h7777_7777, 1'b1, 1'b0, 2, 32'h0F0F_F0F0, 1'b0);
    // store that times out leaves load data alone
    do_access(32'h0000_6000, 32'h9999_9999, 1'b1, 1'b1, 255, 32'h0, 1'b0);
    @(negedge clk); #1;
    check("store timeout data", MEMDATAI, 32'h0F0F_F0F0);
    idle_cycle(1'b0, 32'h0, 1'b0);

    // reset asserted in the second REQ cycle
    @(posedge clk); #1;
    TRANDATADDR = 1'b1; SORL = 1'b0; WRITEMEM = 1'b0; DADDR = 32'h0000_7000;
    BUS_ACK = 1'b0; BUS_ERR = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0; exp_addrerr = 1'b0; exp_buserr = 1'b0;
    exp_memdata = model_mem; bus_chk = 1'b0;
    @(posedge clk); #1;
    exp_req = 1'b1; bus_chk = 1'b1; exp_we = 1'b0; exp_addr = 32'h0000_7000; exp_wdata = DATAO;
    @(posedge clk); #1;
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    check("rst-mid BUS_REQ",  {31'd0, BUS_REQ}, 32'h0);
    check("rst-mid MEMSTALL", {31'd0, MEMSTALL}, 32'h0);
    check("rst-mid MEMDATAI", MEMDATAI, 32'h0);
    check("rst-mid BUSERR",   {31'd0, BUSERR}, 32'h0);
    $display("[TB] reset asserted mid-access");
    @(posedge clk); #1;
    TRANDATADDR = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_mem = 32'h0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_addrerr = 1'b0; exp_buserr = 1'b0;
    exp_memdata = model_mem; bus_chk = 1'b0;
    chk_en = 1'b1;
    idle_cycle(1'b0, 32'h0, 1'b0);

    // fresh load after reset
    base = stall_cnt;
    do_access(32'h0000_3000, 32'h0, 1'b0, 1'b0, 2, 32'hCAFE_F00D, 1'b0);
    @(negedge clk); #1;
    check("post-rst stall cycles", stall_cnt - base, 4);
    check("post-rst data", MEMDATAI, 32'hCAFE_F00D);
    idle_cycle(1'b0, 32'h0, 1'b0);
    idle_cycle(1'b0, 32'h0, 1'b0);
    @(negedge clk); #1;
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
